ibex_irqx_ctrl: RTL and testbench

IBEX_IRQX_CTRL -- requirements
Module: ibex_irqx_ctrl

---
 rtl/ibex_irqx_ctrl.sv | 98 +++++++++
 tb/tb_ibex_irqx_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ibex_irqx_ctrl.sv
// Extended (CLINTx) interrupt controller: per-source edge/level pending capture,
// fixed-priority arbitration and a REQ/ACK handshake towards the core controller.
module ibex_irqx_ctrl #(
   parameter int unsigned NumIrqX = 32,
   parameter int unsigned IdW     = $clog2(NumIrqX)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NumIrqX-1:0] irq_x_i,
   input  logic [NumIrqX-1:0] edge_sel_i,
   input  logic [NumIrqX-1:0] miex_i,
   input  logic [NumIrqX-1:0] mipx_clr_i,
   output logic [NumIrqX-1:0] mipx_o,
   output logic               irq_x_req_o,
   output logic [IdW-1:0]     irq_x_id_o,
   input  logic               irq_x_ack_i
);

   typedef enum logic [1:0] {StIdle, StReq, StAcked} state_e;

   state_e               state_q;
   logic [NumIrqX-1:0]   irq_prev_q;
   logic [NumIrqX-1:0]   pend_q;
   logic [NumIrqX-1:0]   pend_d;
   logic [NumIrqX-1:0]   edge_evt;
   logic [NumIrqX-1:0]   id_oh;
   logic [NumIrqX-1:0]   ack_oh;
   logic [NumIrqX-1:0]   cand;
   logic [IdW-1:0]       winner;
   logic [IdW-1:0]       id_q;
   logic                 req_q;
   logic                 id_live;

   always_comb begin
      edge_evt = irq_x_i & ~irq_prev_q;
      id_oh    = NumIrqX'(1) << id_q;
      ack_oh   = (state_q == StReq && irq_x_ack_i) ? id_oh : '0;
      // A fresh edge event overrides a same-cycle clear or ack.
      pend_d   = (edge_sel_i & (edge_evt | (pend_q & ~mipx_clr_i & ~ack_oh)))
               | (~edge_sel_i & irq_x_i);
      cand     = pend_q & miex_i;
      id_live  = |(cand & id_oh);
      winner   = '0;
      for (int i = NumIrqX - 1; i >= 0; i--) begin
         if (cand[i]) winner = IdW'(i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_prev_q <= '0;
         pend_q     <= '0;
      end else begin
         irq_prev_q <= irq_x_i;
         pend_q     <= pend_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (|cand) begin
                  id_q    <= winner;
                  req_q   <= 1'b1;
                  state_q <= StReq;
               end
            end
            StReq: begin
               // Ack beats withdraw; the latched ID is never preempted.
               if (irq_x_ack_i) begin
                  req_q   <= 1'b0;
                  state_q <= StAcked;
               end else if (!id_live) begin
                  req_q   <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StAcked: begin
               state_q <= StIdle;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign mipx_o      = pend_q;
   assign irq_x_req_o = req_q;
   assign irq_x_id_o  = id_q;

endmodule

// File: tb/tb_ibex_irqx_ctrl.sv
// Directed scoreboard bench for ibex_irqx_ctrl: each step queues the expected
// outputs for the cycle after the next clock edge, then pops and compares them.
module tb_ibex_irqx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] irq, esel, mie, clr;
   logic        ack;
   logic [31:0] mipx;
   logic        req;
   logic [4:0]  id;

   typedef struct {
      string       tag;
      logic        req;
      logic [4:0]  id;
      logic [31:0] mipx;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   ibex_irqx_ctrl #(.NumIrqX(32), .IdW(5)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .irq_x_i     (irq),
      .edge_sel_i  (esel),
      .miex_i      (mie),
      .mipx_clr_i  (clr),
      .mipx_o      (mipx),
      .irq_x_req_o (req),
      .irq_x_id_o  (id),
      .irq_x_ack_i (ack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Queue the expectation for the cycle after the next edge, then compare.
   task automatic step(input string tag, input logic r, input logic [4:0] i,
                       input logic [31:0] m);
      exp_t e;
      e.tag = tag; e.req = r; e.id = i; e.mipx = m;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         check({e.tag, ".req"},  {31'd0, req}, {31'd0, e.req});
         check({e.tag, ".id"},   {27'd0, id},  {27'd0, e.id});
         check({e.tag, ".mipx"}, mipx,         e.mipx);
      end
   endtask

   initial begin
      rst = 1'b1; irq = '0; esel = '0; mie = '0; clr = '0; ack = 1'b0;
      step("rst0", 1'b0, 5'd0, 32'h0);
      step("rst1", 1'b0, 5'd0, 32'h0);
      rst  = 1'b0;
      esel = 32'h0000_1026; // edge sources 1, 2, 5, 12
      mie  = 32'hFFFF_FFFF;

      // Edge source 5: pulse, request, ack.
      irq = 32'h20;
      step("e5_pend", 1'b0, 5'd0, 32'h20);
      irq = '0;
      step("e5_req", 1'b1, 5'd5, 32'h20);
      step("e5_hold", 1'b1, 5'd5, 32'h20);
      ack = 1'b1;
      step("e5_acked", 1'b0, 5'd5, 32'h0);
      ack = 1'b0;
      step("e5_idle", 1'b0, 5'd5, 32'h0);
      step("e5_quiet", 1'b0, 5'd5, 32'h0);

      // Level sources 3 and 7, mask 0x88.
      mie = 32'h88; irq = 32'h88;
      step("l37_pend", 1'b0, 5'd5, 32'h88);
      step("l37_req3", 1'b1, 5'd3, 32'h88);
      ack = 1'b1;
      step("l37_acked", 1'b0, 5'd3, 32'h88);
      ack = 1'b0;
      step("l37_idle", 1'b0, 5'd3, 32'h88);
      step("l37_req3b", 1'b1, 5'd3, 32'h88);
      irq = 32'h80;
      step("l37_fall", 1'b1, 5'd3, 32'h80);
      step("l37_wdraw", 1'b0, 5'd3, 32'h80);
      step("l37_req7", 1'b1, 5'd7, 32'h80);
      ack = 1'b1;
      step("l37_ack7", 1'b0, 5'd7, 32'h80);
      ack = 1'b0; irq = '0;
      step("l37_idle2", 1'b0, 5'd7, 32'h0);
      step("l37_quiet", 1'b0, 5'd7, 32'h0);

      // No preemption: level 9 in REQ, edge 2 arrives.
      mie = 32'hFFFF_FFFF; irq = 32'h200;
      step("np_pend9", 1'b0, 5'd7, 32'h200);
      step("np_req9", 1'b1, 5'd9, 32'h200);
      irq = 32'h204;
      step("np_e2", 1'b1, 5'd9, 32'h204);
      irq = 32'h200;
      step("np_hold9", 1'b1, 5'd9, 32'h204);
      ack = 1'b1;
      step("np_ack9", 1'b0, 5'd9, 32'h204);
      ack = 1'b0;
      step("np_idle", 1'b0, 5'd9, 32'h204);
      step("np_req2", 1'b1, 5'd2, 32'h204);
      ack = 1'b1; irq = '0;
      step("np_ack2", 1'b0, 5'd2, 32'h0);
      ack = 1'b0;
      step("np_idle2", 1'b0, 5'd2, 32'h0);
      step("np_quiet", 1'b0, 5'd2, 32'h0);

      // Level 4 withdraw without ack.
      irq = 32'h10;
      step("wd_pend4", 1'b0, 5'd2, 32'h10);
      step("wd_req4", 1'b1, 5'd4, 32'h10);
      irq = '0;
      step("wd_fall", 1'b1, 5'd4, 32'h0);
      step("wd_drop", 1'b0, 5'd4, 32'h0);
      step("wd_quiet", 1'b0, 5'd4, 32'h0);

      // Edge 1: clear vs. simultaneous edge, then clear alone.
      irq = 32'h2;
      step("c1_pend", 1'b0, 5'd4, 32'h2);
      irq = '0;
      step("c1_req", 1'b1, 5'd1, 32'h2);
      irq = 32'h2; clr = 32'h2;
      step("c1_clr_edge", 1'b1, 5'd1, 32'h2);
      irq = '0; clr = '0;
      step("c1_hold", 1'b1, 5'd1, 32'h2);
      clr = 32'h2;
      step("c1_clr", 1'b1, 5'd1, 32'h0);
      clr = '0;
      step("c1_wdraw", 1'b0, 5'd1, 32'h0);
      step("c1_quiet", 1'b0, 5'd1, 32'h0);

      // Ack outside REQ has no effect.
      mie = '0; irq = 32'h20;
      step("ia_pend", 1'b0, 5'd1, 32'h20);
      irq = '0; ack = 1'b1;
      step("ia_ack", 1'b0, 5'd1, 32'h20);
      ack = 1'b0; clr = 32'h20;
      step("ia_clr", 1'b0, 5'd1, 32'h0);
      clr = '0; mie = 32'hFFFF_FFFF;

      // Reset during REQ, edge source 12 held high across reset release.
      irq = 32'h1000;
      step("r12_pend", 1'b0, 5'd1, 32'h1000);
      step("r12_req", 1'b1, 5'd12, 32'h1000);
      rst = 1'b1;
      step("r12_rst", 1'b0, 5'd0, 32'h0);
      rst = 1'b0;
      step("r12_repend", 1'b0, 5'd0, 32'h1000);
      step("r12_req2", 1'b1, 5'd12, 32'h1000);
      ack = 1'b1; irq = '0;
      step("r12_ack", 1'b0, 5'd12, 32'h0);
      ack = 1'b0;
      step("r12_idle", 1'b0, 5'd12, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
